pc_sequencer: RTL
=================

# pc_sequencer

Multi-cycle control sequencer for the KGPminiRISC datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and asserts the PC, IR, register-file and memory write strobes. It also holds the architectural carry flag, evaluates branch conditions, and drives the select inputs (`lblSel`, `jumpAddr`, `branch`, `validJump`) of the branch unit. The external PC register loads the branch unit's `PC_new` output whenever `pc_we` is high.

## Interface
Parameters:
- none; opcode and funct encodings are fixed, see Operation.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  leave IDLE and begin fetching; sampled only in IDLE
- `opcode`  in  6  opcode field of the external IR; stable from DECODE to end of instruction
- `funct`  in  5  funct field of the external IR
- `rs_val`  in  32  register-file read of rs, used for bltz/bz/bnz
- `alu_carry`  in  1  ALU carry-out, valid in EXEC
- `ir_we`  out  1  load IR from instruction memory
- `pc_we`  out  1  load PC from branch unit `PC_new`
- `reg_we`  out  1  register-file write of ALU or memory result
- `link_we`  out  1  write PC+4 into $ra (bl only)
- `mem_rd`, `mem_wr`  out  1 each  data-memory strobes
- `lblSel`, `jumpAddr`, `branch`, `validJump`  out  1 each  branch-unit controls
- `carry_flag`  out  1  architectural carry flag
- `state`  out  3  current state, for debug
- `halted`  out  1  high in HALT

## Operation
- Opcode classes:
  - 000000: R-type ALU
  - 000001: I-type ALU
  - 000010: lw
  - 000011: sw
  - 000100: branch group
  - 111111: halt
  - any other opcode is a NOP.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, HALT=7.
- State transitions:
  - IDLE: stays in IDLE until `start`=1, then goes to FETCH.
  - FETCH: `ir_we`=1, then DECODE.
  - DECODE: halt goes to HALT; branch group goes to BRANCH; NOP goes to FETCH with `pc_we`=1; everything else goes to EXEC.
  - EXEC: for ALU classes, `carry_flag` <= `alu_carry`. ALU classes go to WB; lw and sw go to MEM.
  - MEM: lw asserts `mem_rd`=1 and goes to WB; sw asserts `mem_wr`=1 and `pc_we`=1 and goes to FETCH.
  - WB: `reg_we`=1 and `pc_we`=1, then FETCH.
  - BRANCH: `branch`=1 and `pc_we`=1; for bl also `link_we`=1. Then FETCH.
  - HALT: absorbing; only `rst` leaves it.
- Branch-group decode by funct, listed as funct: `lblSel`/`jumpAddr`/`validJump`:
  - 0 b: 0/0/1
  - 1 br: x/1/1
  - 2 bltz: 1/0/`rs_val[31]`
  - 3 bz: 1/0/(`rs_val`==0)
  - 4 bnz: 1/0/(`rs_val`!=0)
  - 5 bl: 0/0/1
  - 6 bcy: 0/0/`carry_flag`
  - 7 bncy: 0/0/!`carry_flag`
  - 8–31: reserved, `validJump`=0, so the branch is not taken and PC advances to PC+4.
- Outputs are combinational from the state register, the IR fields and the flags.
- Outside BRANCH, `branch`, `lblSel`, `jumpAddr` and `validJump` are all 0, so `PC_new` = PC+4 whenever `pc_we` fires.
- `carry_flag` changes only in EXEC of an ALU class and on reset. Branches, memory ops and NOPs preserve it.

## Timing
- Reset values: state=IDLE; `carry_flag`=0; every strobe and branch control output 0; `halted`=0.
- `rst` overrides everything. Asserted in any state, including mid-instruction or in HALT, the next edge gives IDLE with no `pc_we`, `reg_we`, `mem_wr` or `link_we` pulse in that cycle.
- Cycles per instruction, FETCH to the cycle after `pc_we`:
  - ALU: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - NOP: 2
  - halt: `halted`=1 on the 3rd cycle after FETCH entry.
- Exactly one `pc_we` pulse per non-halt instruction. HALT never pulses `pc_we`.
- `ir_we` is high for exactly one cycle per instruction. `mem_rd` and `mem_wr` are never high together.
- bcy/bncy read the carry value already registered, i.e. from the most recent ALU instruction. An ALU followed immediately by bcy sees the new carry.
- `start` is ignored outside IDLE. `start` held high continuously has no effect after leaving IDLE.

## Test plan
- Reset, pulse `start`, then issue an R-type ALU op with `alu_carry`=1 -> `ir_we` in cycle 1, `reg_we`=`pc_we`=1 in cycle 4, `carry_flag`=1 from cycle 4 onward.
- Issue lw then sw -> lw: `mem_rd` in cycle 4, `reg_we`+`pc_we` in cycle 5. sw: `mem_wr`+`pc_we` in cycle 4, `reg_we` never asserted.
- Conditional branches:
  - bz with `rs_val`=0 -> in BRANCH, `branch`=1, `lblSel`=1, `validJump`=1.
  - bz with `rs_val`=5 -> `validJump`=0.
  - bltz with `rs_val`=0x80000000 -> `validJump`=1.
- ALU op with carry 1, then bcy, then bncy -> `validJump`=1 for bcy, 0 for bncy. A following sw leaves `carry_flag`=1.
- Unconditional branches:
  - br -> `jumpAddr`=1, `validJump`=1.
  - bl -> `link_we`=1 together with `pc_we` in cycle 3.
  - funct=9 -> `validJump`=0 and `pc_we`=1.
- Halt and reset:
  - halt opcode -> `halted`=1 and `state`=7, held for 20 cycles with no `pc_we`.
  - `rst` -> IDLE next cycle.
  - `rst` asserted during a lw MEM cycle -> IDLE, no `reg_we`, `carry_flag`=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control sequencer for the KGPminiRISC datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH, owns the
// architectural carry flag and drives the branch-unit select lines.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [4:0]  funct,
  input  logic [31:0] rs_val,
  input  logic        alu_carry,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        link_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        lblSel,
  output logic        jumpAddr,
  output logic        branch,
  output logic        validJump,
  output logic        carry_flag,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_carry;

  logic w_is_alu, w_is_lw, w_is_sw, w_is_brg, w_is_halt, w_is_nop;

  logic w_ir_we, w_pc_we, w_reg_we, w_link_we, w_mem_rd, w_mem_wr;
  logic w_lblSel, w_jumpAddr, w_branch, w_validJump;

  // Opcode class decode from the external IR.
  always_comb begin
    w_is_alu  = (opcode == 6'b000000) || (opcode == 6'b000001);
    w_is_lw   = (opcode == 6'b000010);
    w_is_sw   = (opcode == 6'b000011);
    w_is_brg  = (opcode == 6'b000100);
    w_is_halt = (opcode == 6'b111111);
    w_is_nop  = !(w_is_alu || w_is_lw || w_is_sw || w_is_brg || w_is_halt);
  end

  // State register and carry flag; carry only updates in EXEC of an ALU op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC && w_is_alu)
        r_carry <= alu_carry;
    end
  end

  // Next-state, raw strobes and branch-group select decode.
  always_comb begin
    w_next      = r_state;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_reg_we    = 1'b0;
    w_link_we   = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    w_lblSel    = 1'b0;
    w_jumpAddr  = 1'b0;
    w_branch    = 1'b0;
    w_validJump = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start)
          w_next = S_FETCH;
      end
      S_FETCH: begin
        w_ir_we = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_halt)
          w_next = S_HALT;
        else if (w_is_brg)
          w_next = S_BRANCH;
        else if (w_is_nop) begin
          w_pc_we = 1'b1;
          w_next  = S_FETCH;
        end else
          w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = w_is_alu ? S_WB : S_MEM;
      end
      S_MEM: begin
        if (w_is_lw) begin
          w_mem_rd = 1'b1;
          w_next   = S_WB;
        end else begin
          w_mem_wr = 1'b1;
          w_pc_we  = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        w_branch  = 1'b1;
        w_pc_we   = 1'b1;
        w_link_we = (funct == 5'd5);
        case (funct)
          5'd0: w_validJump = 1'b1;
          5'd1: begin
            w_jumpAddr  = 1'b1;
            w_validJump = 1'b1;
          end
          5'd2: begin
            w_lblSel    = 1'b1;
            w_validJump = rs_val[31];
          end
          5'd3: begin
            w_lblSel    = 1'b1;
            w_validJump = (rs_val == '0);
          end
          5'd4: begin
            w_lblSel    = 1'b1;
            w_validJump = (rs_val != '0);
          end
          5'd5: w_validJump = 1'b1;
          5'd6: w_validJump = r_carry;
          5'd7: w_validJump = !r_carry;
          default: w_validJump = 1'b0;
        endcase
        w_next = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are masked while rst is high so a reset cycle has no side effects.
  always_comb begin
    ir_we     = w_ir_we     & ~rst;
    pc_we     = w_pc_we     & ~rst;
    reg_we    = w_reg_we    & ~rst;
    link_we   = w_link_we   & ~rst;
    mem_rd    = w_mem_rd    & ~rst;
    mem_wr    = w_mem_wr    & ~rst;
    lblSel    = w_lblSel    & ~rst;
    jumpAddr  = w_jumpAddr  & ~rst;
    branch    = w_branch    & ~rst;
    validJump = w_validJump & ~rst;
    carry_flag = r_carry;
    state      = r_state;
    halted     = (r_state == S_HALT);
  end

endmodule
